// File: rtl/iterative_divider_pkg.sv
// rtl/iterative_divider_pkg.sv - shared state encoding and width default for the divider
package iterative_divider_pkg;

  localparam int DEFAULT_WIDTH = 32;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } div_state_t;

endpackage

// File: rtl/iterative_divider_step.sv
// rtl/iterative_divider_step.sv - one restoring division iteration (compare/subtract)
module div_step
  import iterative_divider_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input  logic [WIDTH-1:0] i_prem,
  input  logic             i_dvd_msb,
  input  logic [WIDTH-1:0] i_divisor,
  output logic [WIDTH-1:0] o_prem_next,
  output logic             o_qbit
);

  logic [WIDTH:0] w_shift;
  logic [WIDTH:0] w_diff;

  // One extra bit so the shifted remainder never overflows the compare.
  assign w_shift     = {i_prem, i_dvd_msb};
  assign w_diff      = w_shift - {1'b0, i_divisor};
  assign o_qbit      = ~w_diff[WIDTH];
  assign o_prem_next = o_qbit ? w_diff[WIDTH-1:0] : w_shift[WIDTH-1:0];

endmodule

// File: rtl/iterative_divider.sv
// rtl/iterative_divider.sv - multicycle restoring divider, one quotient bit per clock
module iterative_divider
  import iterative_divider_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input  logic             i_clock,
  input  logic             i_reset_n,
  input  logic             i_start,
  input  logic             i_signed_op,
  input  logic [WIDTH-1:0] i_data1,
  input  logic [WIDTH-1:0] i_data2,
  output logic             o_busy,
  output logic             o_result_ready,
  output logic [WIDTH-1:0] o_quotient,
  output logic [WIDTH-1:0] o_remainder,
  output logic             o_div_by_zero
);

  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  div_state_t       r_state;
  logic [CW-1:0]    r_count;
  logic [WIDTH-1:0] r_prem;
  logic [WIDTH-1:0] r_dvd;
  logic [WIDTH-1:0] r_divisor;
  logic             r_qsign;
  logic             r_rsign;
  logic             r_zero;
  logic             r_busy;
  logic             r_ready;
  logic [WIDTH-1:0] r_quotient;
  logic [WIDTH-1:0] r_remainder;
  logic             r_dbz;

  logic             w_sign1;
  logic             w_sign2;
  logic             w_zero;
  logic [WIDTH-1:0] w_mag1;
  logic [WIDTH-1:0] w_mag2;
  logic [WIDTH-1:0] w_prem_next;
  logic             w_qbit;
  logic [WIDTH-1:0] w_q_fix;
  logic [WIDTH-1:0] w_r_fix;

  assign w_sign1 = i_signed_op & i_data1[WIDTH-1];
  assign w_sign2 = i_signed_op & i_data2[WIDTH-1];
  assign w_zero  = (i_data2 == '0);
  assign w_mag1  = w_sign1 ? (~i_data1 + 1'b1) : i_data1;
  assign w_mag2  = w_sign2 ? (~i_data2 + 1'b1) : i_data2;
  assign w_q_fix = r_qsign ? (~r_dvd + 1'b1) : r_dvd;
  assign w_r_fix = r_rsign ? (~r_prem + 1'b1) : r_prem;

  div_step #(.WIDTH(WIDTH)) u_step (
    .i_prem      (r_prem),
    .i_dvd_msb   (r_dvd[WIDTH-1]),
    .i_divisor   (r_divisor),
    .o_prem_next (w_prem_next),
    .o_qbit      (w_qbit)
  );

  // The dividend register doubles as the quotient shift register during RUN.
  always_ff @(posedge i_clock or negedge i_reset_n) begin
    if (!i_reset_n) begin
      r_state     <= ST_IDLE;
      r_count     <= '0;
      r_prem      <= '0;
      r_dvd       <= '0;
      r_divisor   <= '0;
      r_qsign     <= 1'b0;
      r_rsign     <= 1'b0;
      r_zero      <= 1'b0;
      r_busy      <= 1'b0;
      r_ready     <= 1'b0;
      r_quotient  <= '0;
      r_remainder <= '0;
      r_dbz       <= 1'b0;
    end else begin
      r_ready <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          if (i_start) begin
            r_divisor <= w_mag2;
            r_dvd     <= w_zero ? i_data1 : w_mag1;
            r_prem    <= '0;
            r_count   <= '0;
            r_qsign   <= w_sign1 ^ w_sign2;
            r_rsign   <= w_sign1;
            r_zero    <= w_zero;
            r_busy    <= 1'b1;
            r_state   <= w_zero ? ST_DONE : ST_RUN;
          end
        end
        ST_RUN: begin
          r_prem  <= w_prem_next;
          r_dvd   <= {r_dvd[WIDTH-2:0], w_qbit};
          r_count <= r_count + 1'b1;
          if (r_count == CW'(WIDTH - 1)) r_state <= ST_DONE;
        end
        ST_DONE: begin
          r_busy  <= 1'b0;
          r_ready <= 1'b1;
          r_state <= ST_IDLE;
          if (r_zero) begin
            r_quotient  <= '1;
            r_remainder <= r_dvd;
            r_dbz       <= 1'b1;
          end else begin
            r_quotient  <= w_q_fix;
            r_remainder <= w_r_fix;
            r_dbz       <= 1'b0;
          end
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  assign o_busy         = r_busy;
  assign o_result_ready = r_ready;
  assign o_quotient     = r_quotient;
  assign o_remainder    = r_remainder;
  assign o_div_by_zero  = r_dbz;

endmodule
